// File: rtl/detector_borda_pkg.sv
`default_nettype none
// ============================================================================
// detector_borda_pkg : modo encodings and parameter limits for the detector
// Rev 1.0
// ============================================================================
package detector_borda_pkg;

   localparam logic [1:0] MODO_DESLIGADO = 2'b00;
   localparam logic [1:0] MODO_SUBIDA    = 2'b01;
   localparam logic [1:0] MODO_DESCIDA   = 2'b10;
   localparam logic [1:0] MODO_AMBAS     = 2'b11;

   localparam int N_MIN            = 1;
   localparam int N_MAX            = 32;
   localparam int SYNC_STAGES_MIN  = 2;
   localparam int SYNC_STAGES_MAX  = 4;
   localparam int DEBOUNCE_MIN     = 1;
   localparam int DEBOUNCE_MAX     = 255;
   localparam int CNT_W_MIN        = 4;
   localparam int CNT_W_MAX        = 32;

   // Wide enough for DEBOUNCE_MAX
   localparam int DEB_CNT_W        = 8;

endpackage
`default_nettype wire

// File: rtl/detector_borda_multi_if.sv
`default_nettype none
// ============================================================================
// detector_borda_multi_if : channel inputs, controls and event outputs
// Rev 1.0
// ============================================================================
interface detector_borda_multi_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);
   logic [N-1:0]     entrada;
   logic [2*N-1:0]   modo;
   logic [N-1:0]     limpar;
   logic             zerar_contagem;
   logic [N-1:0]     pulso;
   logic [N-1:0]     pendente;
   logic             irq;
   logic [CNT_W-1:0] contagem;

   modport master (
      output entrada, modo, limpar, zerar_contagem,
      input  pulso, pendente, irq, contagem
   );

   modport slave (
      input  entrada, modo, limpar, zerar_contagem,
      output pulso, pendente, irq, contagem
   );
endinterface
`default_nettype wire

// File: rtl/detector_borda_canal.sv
`default_nettype none
// ============================================================================
// detector_borda_canal : one channel - synchroniser, debounce, edge pulse
// Rev 1.0
// ============================================================================
module detector_borda_canal
   import detector_borda_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       entrada,
   input  wire logic [1:0] modo,
   output logic            pulso
);

   localparam logic [DEB_CNT_W-1:0] C_DEB_LAST = DEB_CNT_W'(DEBOUNCE - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_filt;
   logic [DEB_CNT_W-1:0]   r_cnt;
   logic                   r_pulso;

   logic w_nivel;
   logic w_difere;
   logic w_toggle;
   logic w_sobe_ok;
   logic w_desce_ok;
   logic w_evento;

   assign w_nivel    = r_sync[SYNC_STAGES-1];
   assign w_difere   = (w_nivel != r_filt);
   // The edge that would bring the count to DEBOUNCE flips the filtered level
   assign w_toggle   = w_difere && (r_cnt == C_DEB_LAST);
   assign w_sobe_ok  = (modo == MODO_SUBIDA)  || (modo == MODO_AMBAS);
   assign w_desce_ok = (modo == MODO_DESCIDA) || (modo == MODO_AMBAS);
   assign w_evento   = w_toggle && ((!r_filt && w_sobe_ok) || (r_filt && w_desce_ok));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_filt  <= 1'b0;
         r_cnt   <= '0;
         r_pulso <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], entrada};
         r_pulso <= w_evento;
         if (!w_difere) begin
            r_cnt <= '0;
         end else if (w_toggle) begin
            r_filt <= ~r_filt;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign pulso = r_pulso;

endmodule
`default_nettype wire

// File: rtl/detector_borda_multi.sv
`default_nettype none
// ============================================================================
// detector_borda_multi : N debounced edge detectors, sticky flags, irq, count
// Rev 1.0
// ============================================================================
module detector_borda_multi
   import detector_borda_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 8
) (
   input wire logic              clk,
   input wire logic              rst,
   detector_borda_multi_if.slave bus
);

   localparam int PC_W  = $clog2(N + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] C_SAT = SUM_W'({CNT_W{1'b1}});

   logic [N-1:0]     w_pulso;
   logic [N-1:0]     r_pendente;
   logic [CNT_W-1:0] r_contagem;
   logic [PC_W-1:0]  w_pop;
   logic [SUM_W-1:0] w_base;
   logic [SUM_W-1:0] w_soma;

   generate
      for (genvar i = 0; i < N; i++) begin : g_canal
         detector_borda_canal #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
         ) u_canal (
            .clk     (clk),
            .rst     (rst),
            .entrada (bus.entrada[i]),
            .modo    (bus.modo[2*i +: 2]),
            .pulso   (w_pulso[i])
         );
      end
   endgenerate

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < N; k++) begin
         w_pop = w_pop + PC_W'(w_pulso[k]);
      end
   end

   // zerar_contagem restarts the total from this cycle's events
   assign w_base = bus.zerar_contagem ? '0 : SUM_W'(r_contagem);
   assign w_soma = w_base + SUM_W'(w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pendente <= '0;
         r_contagem <= '0;
      end else begin
         r_pendente <= (r_pendente & ~bus.limpar) | w_pulso;
         r_contagem <= (w_soma > C_SAT) ? {CNT_W{1'b1}} : w_soma[CNT_W-1:0];
      end
   end

   assign bus.pulso    = w_pulso;
   assign bus.pendente = r_pendente;
   assign bus.contagem = r_contagem;
   assign bus.irq      = |r_pendente;

endmodule
`default_nettype wire

// File: tb/tb_detector_borda_multi.sv
`default_nettype none
// ============================================================================
// tb_detector_borda_multi : directed self-checking bench, N=4 SYNC=2 DEB=4
// Rev 1.0
// ============================================================================
module tb_detector_borda_multi;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [3:0] seen;

   always #5 clk = ~clk;

   detector_borda_multi_if #(.N(4), .CNT_W(8)) bus ();

   detector_borda_multi #(
      .N           (4),
      .SYNC_STAGES (2),
      .DEBOUNCE    (4),
      .CNT_W       (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic toggle(input logic [3:0] m);
      bus.entrada = bus.entrada ^ m;
      tick(8);
   endtask

   initial begin
      rst                = 1'b1;
      bus.entrada        = 4'h0;
      bus.modo           = 8'h00;
      bus.limpar         = 4'h0;
      bus.zerar_contagem = 1'b0;
      tick(3);
      chk("rst_pulso",    32'(bus.pulso),    32'h0);
      chk("rst_pendente", 32'(bus.pendente), 32'h0);
      chk("rst_irq",      32'(bus.irq),      32'h0);
      chk("rst_contagem", 32'(bus.contagem), 32'h0);

      // Rise on ch0, latency 6 edges
      rst         = 1'b0;
      bus.modo    = 8'b0000_0001;
      bus.entrada = 4'b0001;
      tick(5);
      chk("rise_e5", 32'(bus.pulso), 32'h0);
      tick(1);
      chk("rise_e6", 32'(bus.pulso), 32'h1);
      tick(1);
      chk("rise_e7",      32'(bus.pulso),    32'h0);
      chk("rise_pend",    32'(bus.pendente), 32'h1);
      chk("rise_irq",     32'(bus.irq),      32'h1);
      chk("rise_cont",    32'(bus.contagem), 32'h1);

      // 3-cycle glitch on ch1 (fall mode), plus a modo change on ch0
      bus.modo    = 8'b0000_1011;
      bus.entrada = 4'b0011;
      tick(3);
      bus.entrada = 4'b0001;
      seen = 4'h0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         seen = seen | bus.pulso;
      end
      chk("glitch_pulso", 32'(seen),          32'h0);
      chk("glitch_cont",  32'(bus.contagem),  32'h1);
      chk("glitch_pend",  32'(bus.pendente),  32'h1);

      // ch0 falls with modo off: no event
      bus.modo    = 8'h00;
      bus.entrada = 4'h0;
      tick(10);
      chk("off_cont", 32'(bus.contagem), 32'h1);
      bus.zerar_contagem = 1'b1;
      tick(1);
      bus.zerar_contagem = 1'b0;
      chk("zerar_idle", 32'(bus.contagem), 32'h0);

      // All channels, both edges
      bus.modo    = 8'hFF;
      bus.entrada = 4'hF;
      tick(5);
      chk("all_rise_e5", 32'(bus.pulso), 32'h0);
      tick(1);
      chk("all_rise_e6", 32'(bus.pulso), 32'hF);
      tick(1);
      chk("all_rise_cont", 32'(bus.contagem), 32'h4);
      chk("all_rise_pend", 32'(bus.pendente), 32'hF);
      bus.entrada = 4'h0;
      tick(6);
      chk("all_fall_e6", 32'(bus.pulso), 32'hF);
      tick(1);
      chk("all_fall_cont", 32'(bus.contagem), 32'h8);

      // pendente: set wins over simultaneous limpar
      bus.limpar = 4'hF;
      tick(1);
      bus.limpar = 4'h0;
      chk("clr_pend", 32'(bus.pendente), 32'h0);
      chk("clr_irq",  32'(bus.irq),      32'h0);
      bus.entrada = 4'b0100;
      tick(6);
      chk("ch2_pulso", 32'(bus.pulso), 32'h4);
      bus.limpar = 4'b0100;
      tick(1);
      chk("setwins_pend", 32'(bus.pendente), 32'h4);
      tick(1);
      bus.limpar = 4'h0;
      chk("clr2_pend", 32'(bus.pendente), 32'h0);
      chk("clr2_irq",  32'(bus.irq),      32'h0);

      // Saturation of contagem
      tick(2);
      bus.zerar_contagem = 1'b1;
      tick(1);
      bus.zerar_contagem = 1'b0;
      chk("sat_zero", 32'(bus.contagem), 32'h0);
      for (int k = 0; k < 63; k++) toggle(4'hF);
      chk("sat_252", 32'(bus.contagem), 32'd252);
      toggle(4'b0011);
      chk("sat_254", 32'(bus.contagem), 32'd254);
      toggle(4'b1100);
      chk("sat_255", 32'(bus.contagem), 32'd255);
      toggle(4'b0001);
      chk("sat_hold", 32'(bus.contagem), 32'd255);
      bus.entrada = bus.entrada ^ 4'b0010;
      tick(6);
      chk("zerar_ev_pulso", 32'(bus.pulso), 32'h2);
      bus.zerar_contagem = 1'b1;
      tick(1);
      bus.zerar_contagem = 1'b0;
      chk("zerar_ev_cont", 32'(bus.contagem), 32'h1);

      // Reset mid-debounce
      rst         = 1'b1;
      bus.entrada = 4'h0;
      tick(2);
      rst = 1'b0;
      tick(2);
      chk("rst2_cont", 32'(bus.contagem), 32'h0);
      bus.modo    = 8'hFF;
      bus.entrada = 4'b1000;
      tick(4);
      rst  = 1'b1;
      seen = 4'h0;
      for (int k = 0; k < 2; k++) begin
         tick(1);
         seen = seen | bus.pulso;
      end
      chk("midrst_pulso", 32'(seen), 32'h0);
      rst = 1'b0;
      tick(5);
      chk("after_rst_e5", 32'(bus.pulso), 32'h0);
      tick(1);
      chk("after_rst_e6", 32'(bus.pulso), 32'h8);
      tick(1);
      chk("after_rst_cont", 32'(bus.contagem), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
